// File: rtl/bsg_nonsynth_manycore_target_mem.sv
// Memory target for the manycore endpoint request side: byte-masked word memory,
// one-cycle load/store responses and traffic statistics. Define
// BSG_NONSYNTH_TARGET_MEM_CHECKSUM_EN to build the rotating store checksum.
module bsg_nonsynth_manycore_target_mem
  #(parameter int data_width_p = 32
   ,parameter int addr_width_p = 28
   ,parameter int x_cord_width_p = 7
   ,parameter int y_cord_width_p = 7
   ,parameter int els_p = 1024
   ,parameter logic [data_width_p-1:0] oob_data_p = 32'hDEAD_BEEF
   ,parameter int data_mask_width_lp = data_width_p >> 3
   ,parameter int lg_els_lp = (els_p > 1) ? $clog2(els_p) : 1
   )
   (input  logic                                     clk_i
   ,input  logic                                     reset_n_i
   ,input  logic                                     v_i
   ,input  logic [data_width_p-1:0]                  data_i
   ,input  logic [data_mask_width_lp-1:0]            mask_i
   ,input  logic [addr_width_p-1:0]                  addr_i
   ,input  logic                                     we_i
   ,input  logic [x_cord_width_p-1:0]                src_x_cord_i
   ,input  logic [y_cord_width_p-1:0]                src_y_cord_i
   ,input  logic                                     freeze_i
   ,output logic                                     yumi_o
   ,output logic [data_width_p-1:0]                  data_o
   ,output logic                                     v_o
   ,output logic [31:0]                              store_count_o
   ,output logic [31:0]                              load_count_o
   ,output logic                                     oob_error_o
   ,output logic [x_cord_width_p+y_cord_width_p-1:0] last_src_o
   ,output logic [data_width_p-1:0]                  checksum_o
   );

   // Range compare is done wide enough that neither operand gets truncated.
   localparam int cmp_w_lp = (addr_width_p > 32) ? addr_width_p + 1 : 33;

   logic [data_width_p-1:0] mem [els_p];
   logic [lg_els_lp-1:0]    idx;
   logic                    in_range;

   assign yumi_o   = v_i & ~freeze_i & reset_n_i;
   assign idx      = addr_i[lg_els_lp-1:0];
   assign in_range = (cmp_w_lp'(addr_i) < cmp_w_lp'(els_p));

   // Memory is intentionally not reset; unwritten words read back as X.
   always_ff @(posedge clk_i) begin
      if (yumi_o & we_i & in_range) begin
         for (int b = 0; b < data_mask_width_lp; b++) begin
            if (mask_i[b]) mem[idx][8*b +: 8] <= data_i[8*b +: 8];
         end
      end
   end

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) begin
         v_o           <= 1'b0;
         data_o        <= '0;
         store_count_o <= '0;
         load_count_o  <= '0;
         oob_error_o   <= 1'b0;
         last_src_o    <= '0;
      end else begin
         v_o <= yumi_o;
         if (yumi_o) begin
            last_src_o <= {src_y_cord_i, src_x_cord_i};
            if (!in_range) oob_error_o <= 1'b1;
            if (we_i) begin
               data_o <= '0;
               if (store_count_o != '1) store_count_o <= store_count_o + 32'd1;
            end else begin
               data_o <= in_range ? mem[idx] : oob_data_p;
               if (load_count_o != '1) load_count_o <= load_count_o + 32'd1;
            end
         end
      end
   end

`ifdef BSG_NONSYNTH_TARGET_MEM_CHECKSUM_EN
   logic [data_width_p-1:0]              mask_exp;
   logic [data_width_p+addr_width_p-1:0] addr_wide;

   always_comb begin
      mask_exp = '0;
      for (int b = 0; b < data_mask_width_lp; b++) mask_exp[8*b +: 8] = {8{mask_i[b]}};
   end

   assign addr_wide = (data_width_p+addr_width_p)'(addr_i);

   always_ff @(posedge clk_i) begin
      if (!reset_n_i) checksum_o <= '0;
      else if (yumi_o & we_i & in_range)
         checksum_o <= {checksum_o[data_width_p-2:0], checksum_o[data_width_p-1]}
                       ^ (data_i & mask_exp) ^ addr_wide[data_width_p-1:0];
   end
`else
   assign checksum_o = '0;
`endif

endmodule
